// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, FIFO read strobe leading the visible pixel by RD_LEAD clocks.
// Optional VTG_UNDERFLOW_CNT_EN adds a saturating 16-bit underflow event counter.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int RD_LEAD  = 1,
    parameter int XW       = 10,
    parameter int YW       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          fifo_empty,
    input  logic          clr_underflow,
    output logic          rd_fifo,
    output logic          hsync,
    output logic          vsync,
    output logic          blank,
    output logic [XW-1:0] pixel_x,
    output logic [YW-1:0] pixel_y,
    output logic          frame_start,
    output logic          running,
`ifdef VTG_UNDERFLOW_CNT_EN
    output logic [15:0]   underflow_cnt,
`endif
    output logic          underflow
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG_C = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END_C = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG_C = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END_C = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);

    generate
        if (XW < $clog2(H_ACTIVE) || YW < $clog2(V_ACTIVE)) begin : g_bad_width
            $fatal(1, "video_timing_gen: XW/YW too narrow for active area");
        end
        if (RD_LEAD < 0 || RD_LEAD > 3) begin : g_bad_lead
            $fatal(1, "video_timing_gen: RD_LEAD must be 0..3");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, IDLE_PEND} state_t;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          blank;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          fs;
    } tim_t;

    localparam tim_t IDLE_T = '{hs: ~HS_POL, vs: ~VS_POL, blank: 1'b1,
                                x: '0, y: '0, fs: 1'b0};

    state_t        state;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          act;
    logic          frame_end;
    tim_t          cur;
    tim_t          pipe [0:RD_LEAD];

    assign frame_end = (h == H_LAST_C) && (v == V_LAST_C);

    // Counter decode is gated by state so the held (0,0) in IDLE never looks active.
    always_comb begin
        cur = IDLE_T;
        act = 1'b0;
        if (state != IDLE) begin
            act       = (h < H_ACT_C) && (v < V_ACT_C);
            cur.hs    = (h >= HS_BEG_C && h < HS_END_C) ? HS_POL : ~HS_POL;
            cur.vs    = (v >= VS_BEG_C && v < VS_END_C) ? VS_POL : ~VS_POL;
            cur.blank = ~act;
            cur.x     = act ? XW'(h) : '0;
            cur.y     = act ? YW'(v) : '0;
            cur.fs    = act && (h == '0) && (v == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            h         <= '0;
            v         <= '0;
            rd_fifo   <= 1'b0;
            running   <= 1'b0;
            underflow <= 1'b0;
            for (int i = 0; i <= RD_LEAD; i++) pipe[i] <= IDLE_T;
        end else begin
            case (state)
                IDLE:      if (enable && !fifo_empty) state <= RUN;
                RUN:       if (!enable) state <= IDLE_PEND;
                IDLE_PEND: if (enable) state <= RUN;
                           else if (frame_end) state <= IDLE;
                default:   state <= IDLE;
            endcase
            if (state != IDLE) begin
                if (h == H_LAST_C) begin
                    h <= '0;
                    v <= (v == V_LAST_C) ? '0 : v + 1'b1;
                end else begin
                    h <= h + 1'b1;
                end
            end
            rd_fifo   <= act;
            running   <= (state != IDLE);
            underflow <= (rd_fifo && fifo_empty) || (underflow && !clr_underflow);
            pipe[0]   <= cur;
            for (int i = 1; i <= RD_LEAD; i++) pipe[i] <= pipe[i-1];
        end
    end

`ifdef VTG_UNDERFLOW_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            underflow_cnt <= '0;
        end else if (rd_fifo && fifo_empty) begin
            if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
        end else if (clr_underflow) begin
            underflow_cnt <= '0;
        end
    end
`endif

    assign hsync       = pipe[RD_LEAD].hs;
    assign vsync       = pipe[RD_LEAD].vs;
    assign blank       = pipe[RD_LEAD].blank;
    assign pixel_x     = pipe[RD_LEAD].x;
    assign pixel_y     = pipe[RD_LEAD].y;
    assign frame_start = pipe[RD_LEAD].fs;
endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: a frame-position reference model queues expected outputs each clock, a monitor compares.
module tb_video_timing_gen;
    localparam int HA = 8, HF = 2, HS = 3, HB = 1;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int LEAD = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       fifo_empty = 1'b0;
    logic       clr_underflow = 1'b0;
    logic       rd_fifo, hsync, vsync, blank, frame_start, running, underflow;
    logic [9:0] pixel_x, pixel_y;
    logic [15:0] cnt_dut;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .RD_LEAD(LEAD), .XW(10), .YW(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
        .clr_underflow(clr_underflow), .rd_fifo(rd_fifo), .hsync(hsync),
        .vsync(vsync), .blank(blank), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .frame_start(frame_start), .running(running),
`ifdef VTG_UNDERFLOW_CNT_EN
        .underflow_cnt(cnt_dut),
`endif
        .underflow(underflow)
    );
`ifndef VTG_UNDERFLOW_CNT_EN
    assign cnt_dut = '0;
`endif

    typedef struct packed {
        logic rd, hs, vs, bl;
        logic [9:0] x, y;
        logic fs, run, uf;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    // Reference: pos is the raster position within the frame (-1 when idle).
    int   pos = -1;
    bit   pend = 0;
    int   hist [0:LEAD];
    bit   rd_m = 0, run_m = 0, uf_m = 0;
    int   cnt_m = 0;

    function automatic exp_t tim(input int p);
        exp_t e;
        int   hh, vv;
        bit   a;
        e = '0;
        e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b1;
        if (p >= 0) begin
            hh = p % HT;
            vv = p / HT;
            a = (hh < HA) && (vv < VA);
            e.hs = !(hh >= HA + HF && hh < HA + HF + HS);
            e.vs = !(vv >= VA + VF && vv < VA + VF + VS);
            e.bl = !a;
            if (a) begin
                e.x = 10'(hh);
                e.y = 10'(vv);
            end
            e.fs = (p == 0);
        end
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        bit   act0;
        cyc++;
        if (!rst_n) begin
            pos = -1; pend = 0; rd_m = 0; run_m = 0; uf_m = 0; cnt_m = 0;
            for (int i = 0; i <= LEAD; i++) hist[i] = -1;
        end else begin
            act0 = (pos >= 0) && !tim(pos).bl;
            if (rd_m && fifo_empty) begin
                uf_m = 1;
                if (cnt_m < 16'hFFFF) cnt_m++;
            end else if (clr_underflow) begin
                uf_m = 0;
                cnt_m = 0;
            end
            rd_m  = act0;
            run_m = (pos >= 0);
            for (int i = LEAD; i >= 1; i--) hist[i] = hist[i-1];
            hist[0] = pos;
            if (pos < 0) begin
                if (enable && !fifo_empty) begin pos = 0; pend = 0; end
            end else if (pend) begin
                if (enable) begin pend = 0; pos = (pos + 1) % FT; end
                else if (pos == FT - 1) pos = -1;
                else pos = pos + 1;
            end else begin
                if (!enable) pend = 1;
                pos = (pos + 1) % FT;
            end
        end
        e = tim(hist[LEAD]);
        e.rd = rd_m; e.run = run_m; e.uf = uf_m;
`ifdef VTG_UNDERFLOW_CNT_EN
        e.cnt = 16'(cnt_m);
`else
        e.cnt = '0;
`endif
        q.push_back(e);
    end

    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL cyc=%0d scoreboard: no expected entry queued", cyc);
            end else begin
                e = q.pop_front();
                a = '{rd: rd_fifo, hs: hsync, vs: vsync, bl: blank, x: pixel_x, y: pixel_y,
                      fs: frame_start, run: running, uf: underflow, cnt: cnt_dut};
                if (a !== e) begin
                    n_err++;
                    $display("FAIL cyc=%0d outputs: got rd=%b hs=%b vs=%b bl=%b x=%0d y=%0d fs=%b run=%b uf=%b cnt=%0d, need rd=%b hs=%b vs=%b bl=%b x=%0d y=%0d fs=%b run=%b uf=%b cnt=%0d",
                             cyc, a.rd, a.hs, a.vs, a.bl, a.x, a.y, a.fs, a.run, a.uf, a.cnt,
                             e.rd, e.hs, e.vs, e.bl, e.x, e.y, e.fs, e.run, e.uf, e.cnt);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset, then two-plus full frames of continuous scan-out.
        step(3);
        rst_n = 1'b1;
        step(2);
        enable = 1'b1;
        step(2 * FT + 17);
        // Drop enable partway into a frame: scan finishes the frame then idles.
        enable = 1'b0;
        step(FT + 20);
        // Restart and starve the FIFO for one full line.
        enable = 1'b1;
        step(2 * HT + 3);
        fifo_empty = 1'b1;
        step(HT);
        fifo_empty = 1'b0;
        step(10);
        clr_underflow = 1'b1;
        step(1);
        clr_underflow = 1'b0;
        step(20);
        // Clear coinciding with fresh underflow events.
        fifo_empty = 1'b1;
        clr_underflow = 1'b1;
        step(HT);
        fifo_empty = 1'b0;
        step(1);
        clr_underflow = 1'b0;
        step(HT + 5);
        // Reset mid-line with enable held, then a fresh frame.
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(FT + 10);
        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            fifo_empty    = ($urandom_range(0, 15) == 0);
            clr_underflow = ($urandom_range(0, 15) == 0);
            rst_n         = ($urandom_range(0, 499) != 0);
            step(1);
        end
        rst_n = 1'b1;
        enable = 1'b0;
        fifo_empty = 1'b0;
        clr_underflow = 1'b0;
        step(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
